// File: rtl/evm_pkg.sv
// Shared types and helpers for the multi-button vote qualifier.
// State encoding is fixed so the values stay stable for anything that observes the FSM.
package evm_pkg;

    typedef enum logic [1:0] {
        ARMED        = 2'd0,
        LOCKOUT      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_e;

    // Index of the highest set bit; callers pass a one-hot vector zero-extended to 32 bits.
    function automatic logic [4:0] onehot_to_index(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/btn_channel_filter.sv
// One button channel: input synchroniser, polarity fix and saturating hold-time counter.
// qualified stays high while the press has been held HOLD_CYCLES samples and clear is low.
import evm_pkg::*;

module btn_channel_filter #(
    parameter int unsigned HOLD_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    input  logic clear,
    output logic act,
    output logic qualified
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD = CW'(HOLD_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   w_act;

    assign w_act = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], button};
        end
    end

    // Any inactive sample restarts the hold window, which is what rejects contact bounce.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!w_act || clear) begin
            r_cnt <= '0;
        end else if (r_cnt < HOLD) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign act       = w_act;
    assign qualified = (r_cnt == HOLD);

endmodule

// File: rtl/vote_button_array.sv
// N-button vote qualifier: per-channel filters feed one arbiter that issues at most one vote
// per press, then locks out and requires every button released before re-arming.
import evm_pkg::*;

module vote_button_array #(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned HOLD_CYCLES    = 50000,
    parameter int unsigned LOCKOUT_CYCLES = 100000,
    parameter int unsigned RELEASE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter bit          ACTIVE_LOW     = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         button,
    input  logic                    enable,
    output logic [N_CH-1:0]         valid_vote,
    output logic [$clog2(N_CH)-1:0] vote_index,
    output logic                    conflict,
    output logic                    busy
);

    localparam int unsigned IW   = $clog2(N_CH);
    localparam int unsigned TMAX = (LOCKOUT_CYCLES > RELEASE_CYCLES) ? LOCKOUT_CYCLES
                                                                     : RELEASE_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] REL_LAST  = TW'(RELEASE_CYCLES - 1);

    logic [N_CH-1:0] w_act;
    logic [N_CH-1:0] w_qual;
    logic            w_clear;
    logic [5:0]      w_pop;

    state_e          r_state;
    logic [TW-1:0]   r_timer;
    logic [N_CH-1:0] r_valid;
    logic [IW-1:0]   r_index;
    logic            r_conflict;

    assign w_clear = (r_state != ARMED) || !enable;
    assign w_pop   = popcount(32'(w_act));

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_channel_filter #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .SYNC_STAGES (SYNC_STAGES),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_filter (
            .clock     (clock),
            .reset     (reset),
            .button    (button[g]),
            .clear     (w_clear),
            .act       (w_act[g]),
            .qualified (w_qual[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= WAIT_RELEASE;
            r_timer    <= '0;
            r_valid    <= '0;
            r_index    <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_valid    <= '0;
            r_index    <= '0;
            r_conflict <= 1'b0;
            case (r_state)
                ARMED: begin
                    if (|w_qual) begin
                        if (w_pop == 6'd1) begin
                            r_valid <= w_qual;
                            r_index <= IW'(onehot_to_index(32'(w_qual)));
                            r_state <= LOCKOUT;
                            r_timer <= LOCK_LOAD;
                        end else begin
                            r_conflict <= 1'b1;
                            r_state    <= WAIT_RELEASE;
                            r_timer    <= '0;
                        end
                    end
                end
                LOCKOUT: begin
                    if (r_timer == '0) begin
                        r_state <= WAIT_RELEASE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                WAIT_RELEASE: begin
                    // Counts only unbroken all-released cycles, so a held button never re-votes.
                    if (|w_act) begin
                        r_timer <= '0;
                    end else if (r_timer == REL_LAST) begin
                        r_state <= ARMED;
                        r_timer <= '0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= WAIT_RELEASE;
                    r_timer <= '0;
                end
            endcase
        end
    end

    assign valid_vote = r_valid;
    assign vote_index = r_index;
    assign conflict   = r_conflict;
    assign busy       = (r_state != ARMED);

endmodule

// File: tb/tb_vote_button_array.sv
// Bench for vote_button_array: scoreboard of expected vote/conflict pulses with cycle stamps,
// plus per-scenario tasks checking busy and idle outputs.
module tb_vote_button_array;

    localparam int unsigned N_CH = 4;

    logic            clock;
    logic            reset;
    logic [N_CH-1:0] button;
    logic            enable;
    logic [N_CH-1:0] valid_vote;
    logic [1:0]      vote_index;
    logic            conflict;
    logic            busy;

    typedef struct {
        logic [3:0] vv;
        logic [1:0] idx;
        logic       cf;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   mon_en = 0;

    vote_button_array #(
        .N_CH           (4),
        .HOLD_CYCLES    (4),
        .LOCKOUT_CYCLES (8),
        .RELEASE_CYCLES (3),
        .SYNC_STAGES    (2),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .button     (button),
        .enable     (enable),
        .valid_vote (valid_vote),
        .vote_index (vote_index),
        .conflict   (conflict),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Scoreboard consumer: every pulse must match the head entry, including its edge number.
    always @(negedge clock) begin
        if (mon_en) begin
            if (valid_vote !== 4'b0 || conflict !== 1'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d got vv=%b idx=%0d cf=%b want none",
                             cyc, valid_vote, vote_index, conflict);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (valid_vote !== e.vv || vote_index !== e.idx || conflict !== e.cf ||
                        cyc != e.cyc) begin
                        errors++;
                        $display("FAIL pulse cyc=%0d vv=%b idx=%0d cf=%b want cyc=%0d vv=%b idx=%0d cf=%b",
                                 cyc, valid_vote, vote_index, conflict, e.cyc, e.vv, e.idx, e.cf);
                    end
                end
            end else begin
                checks++;
                if (vote_index !== 2'd0) begin
                    errors++;
                    $display("FAIL idle_index cyc=%0d got %0d want 0", cyc, vote_index);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] vv, input logic [1:0] idx, input logic cf,
                        input int at);
        exp_t e;
        e.vv = vv; e.idx = idx; e.cf = cf; e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic sb_drained(input string tag);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_pulse got %0d pending want 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin
            tick(1);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_rearm_timeout got busy=%b want 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; button = 4'hF; enable = 1'b1;
        tick(2);
        mon_en = 1;
        checks++;
        if (valid_vote !== 4'b0 || vote_index !== 2'd0 || conflict !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs got vv=%b idx=%0d cf=%b busy=%b want 0000/0/0/1",
                     valid_vote, vote_index, conflict, busy);
        end
        reset = 1'b0;
        tick(4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_early_arm got busy=%b want 1", busy);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_arm got busy=%b want 0", busy);
        end
    endtask

    task automatic test_clean_press();
        button = 4'b1011;
        push(4'b0100, 2'd2, 1'b0, cyc + 7);
        tick(8);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL clean_busy_after_vote got %b want 1", busy);
        end
        sb_drained("clean");
        button = 4'hF;
        wait_idle("clean");
    endtask

    task automatic test_bounce();
        button = 4'b1101; tick(3);
        button = 4'b1111; tick(1);
        button = 4'b1101; tick(3);
        button = 4'b1111; tick(6);
        sb_drained("bounce");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bounce_still_armed got busy=%b want 0", busy);
        end
    endtask

    task automatic test_simultaneous();
        button = 4'b0110;
        push(4'b0000, 2'd0, 1'b1, cyc + 7);
        tick(8);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL simul_busy got %b want 1", busy);
        end
        sb_drained("simul");
        button = 4'hF;
        tick(4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL simul_early_rearm got busy=%b want 1", busy);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL simul_rearm got busy=%b want 0", busy);
        end
    endtask

    task automatic test_hold_through();
        button = 4'b1011;
        push(4'b0100, 2'd2, 1'b0, cyc + 7);
        tick(40);
        sb_drained("hold");
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_busy got %b want 1", busy);
        end
        button = 4'hF;
        tick(5);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_rearm got busy=%b want 0", busy);
        end
        button = 4'b1110;
        push(4'b0001, 2'd0, 1'b0, cyc + 7);
        tick(8);
        sb_drained("hold_second");
        button = 4'hF;
        wait_idle("hold");
    endtask

    task automatic test_gate_reset();
        enable = 1'b0;
        button = 4'b1011;
        tick(12);
        sb_drained("gate");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL gate_armed got busy=%b want 0", busy);
        end
        button = 4'hF;
        enable = 1'b1;
        tick(4);
        button = 4'b0111;
        tick(6);
        reset = 1'b1;
        tick(1);
        checks++;
        if (valid_vote !== 4'b0 || vote_index !== 2'd0 || conflict !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort got vv=%b idx=%0d cf=%b busy=%b want 0000/0/0/1",
                     valid_vote, vote_index, conflict, busy);
        end
        reset = 1'b0;
        button = 4'hF;
        tick(2);
        sb_drained("reset_abort");
        wait_idle("reset_abort");
    endtask

    task automatic test_lockout_window();
        button = 4'b1011;
        push(4'b0100, 2'd2, 1'b0, cyc + 7);
        tick(7);
        button = 4'b1101;
        tick(20);
        sb_drained("lockout");
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL lockout_held_busy got %b want 1", busy);
        end
        button = 4'hF;
        tick(4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL lockout_early_rearm got busy=%b want 1", busy);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL lockout_rearm got busy=%b want 0", busy);
        end
        tick(10);
        sb_drained("lockout_tail");
    endtask

    initial begin
        reset = 1'b1;
        button = 4'hF;
        enable = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_hold_through();
        test_gate_reset();
        test_lockout_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vote_button_array.md
Name: vote_button_array

Overview:
- Parametrised successor to the single-button vote qualifier. It serves N candidate buttons with a synchroniser and hold-time filter per channel.
- A global arbiter issues at most one qualified vote per press, as a one-hot pulse plus a binary index.
- The arbiter also enforces post-vote lockout, simultaneous-press rejection and a mandatory all-released re-arm.
- Sits between the raw ballot-unit buttons and the vote tally counters.

Parameters:
- N_CH, 4, number of candidate buttons (2..32).
- HOLD_CYCLES, 50000, consecutive active samples needed to qualify a press (>=2).
- LOCKOUT_CYCLES, 100000, cycles after a vote during which all buttons are ignored (>=1).
- RELEASE_CYCLES, 50000, consecutive cycles all buttons must be inactive before re-arming (>=1).
- SYNC_STAGES, 2, flops in each input synchroniser (>=2).
- ACTIVE_LOW, 1, 1 means a button reads pressed when its input is 0.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- button  input  N_CH  raw asynchronous button levels.
- enable  input  1  voting window open; low means no votes are qualified.
- valid_vote  output  N_CH  one-hot, single-cycle pulse marking the qualified candidate.
- vote_index  output  $clog2(N_CH)  binary candidate index; valid only while valid_vote is nonzero, otherwise 0.
- conflict  output  1  single-cycle pulse: simultaneous press rejected.
- busy  output  1  high whenever the FSM is not ARMED.

Behaviour:
- Interface: one clock, named clock. Reset is named reset and is synchronous, active-high.
- Reset: all synchronisers, counters and timers go to 0. valid_vote=0, vote_index=0, conflict=0. FSM goes to WAIT_RELEASE, so busy=1 and buttons must be seen released before the first vote.
- Reset mid-operation aborts any pending pulse.
- Per channel:
  - act[i] = synchronised button[i] XOR ACTIVE_LOW.
  - cnt[i] width is $clog2(HOLD_CYCLES+1).
  - If act[i]=0, or state!=ARMED, or enable=0: cnt[i] <= 0.
  - Else if cnt[i] < HOLD_CYCLES: cnt[i] <= cnt[i]+1.
  - Otherwise cnt[i] saturates.
  - Any inactive sample (bounce) clears cnt[i].
- Qualify event: in ARMED, any cnt[i]==HOLD_CYCLES.
- FSM states: ARMED, LOCKOUT, WAIT_RELEASE.
- ARMED, on a qualify event with popcount(act)==1:
  - Register valid_vote = one-hot of that channel and vote_index = its index for exactly one cycle.
  - Go to LOCKOUT and load the timer with LOCKOUT_CYCLES-1.
- ARMED, on a qualify event with popcount(act)>1 (including two channels reaching HOLD in the same cycle):
  - Register a conflict pulse for one cycle; valid_vote stays 0.
  - Go to WAIT_RELEASE and clear the timer.
- LOCKOUT: the timer decrements every cycle regardless of enable. At 0, go to WAIT_RELEASE.
- WAIT_RELEASE:
  - The timer counts consecutive cycles with all act==0; any active channel clears it.
  - When it reaches RELEASE_CYCLES-1 with all act still 0, go to ARMED.
  - A held button therefore can never vote twice.
- Latency, with one button held steadily from before edge 1 and the FSM in ARMED:
  - sync output active after edge SYNC_STAGES;
  - cnt==HOLD_CYCLES after edge SYNC_STAGES+HOLD_CYCLES;
  - valid_vote high after edge SYNC_STAGES+HOLD_CYCLES+1, for one cycle.
- enable falling mid-count clears the counters, so no vote is issued. enable does not affect the LOCKOUT or WAIT_RELEASE timers.
- valid_vote and conflict are never high in the same cycle. At most one valid_vote bit is set.
- All outputs are registered.

Decomposition:
- Package evm_pkg:
  - FSM state encoding localparams: ARMED=2'd0, LOCKOUT=2'd1, WAIT_RELEASE=2'd2.
  - onehot_to_index function.
  - popcount function.
- Sub-module btn_channel_filter:
  - Contains one channel's synchroniser, ACTIVE_LOW polarity fix and saturating counter.
  - Outputs act and qualified.
  - Instantiated N_CH times in a generate loop.
- The arbiter FSM and timers live in the top.

Test Plan (N_CH=4, HOLD_CYCLES=4, LOCKOUT_CYCLES=8, RELEASE_CYCLES=3, SYNC_STAGES=2, ACTIVE_LOW=1):
- Clean press: release all for 3+ cycles after reset, then hold button[2]=0 from edge 1 -> valid_vote=4'b0100 and vote_index=2, for one cycle only, after edge 7; busy=1 afterwards.
- Bounce: button[1] low for 3 cycles, high 1 cycle, low 3 cycles -> no valid_vote and no conflict.
- Simultaneous press: button[0] and button[3] driven low on the same edge and held -> conflict pulse after edge 7, valid_vote=0. Releasing both for 3 cycles re-arms (busy=0).
- Hold-through: keep button[2] low for 40 cycles after a vote -> exactly one vote. No second vote until release for 3 cycles, then a new 4-cycle press.
- Gate/reset: enable=0 during a full press -> no vote. Assert reset in the cycle before an expected pulse -> no pulse, busy=1, all outputs 0.
- Lockout window: after a vote, press button[1] during LOCKOUT -> ignored. Because button[1] is still held, WAIT_RELEASE is not exited until it is released.
